// File: rtl/shift_load_ctrl.sv
// Loads a parallel word MSB-first into a serial-in left-shift register,
// then compares the register's parallel readback with the word it sent.
module shift_load_ctrl #(
    parameter int WIDTH = 4,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             sd,
    output logic             sen,
    input  logic [WIDTH-1:0] q,
    output logic             done,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] IDX_TOP  = CNT_W'(WIDTH - 2);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [ERR_W-1:0] ERR_ONE  = ERR_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        CHECK
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             sd_q, sd_d;
    logic             sen_q, sen_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0] bit_idx;
    logic             mismatch;

    assign in_ready = (state_q == IDLE);
    assign sd       = sd_q;
    assign sen      = sen_q;
    assign done     = done_q;
    assign err      = err_q;
    assign err_cnt  = err_cnt_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        word_d    = word_q;
        sd_d      = sd_q;
        sen_d     = sen_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        err_cnt_d = err_cnt_q;
        // The MSB already went out on the accept edge, so count c sends bit WIDTH-2-c.
        bit_idx   = IDX_TOP - cnt_q;
        mismatch  = (q != word_q);

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    word_d  = in_data;
                    sd_d    = in_data[WIDTH-1];
                    sen_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q == CNT_LAST) begin
                    sd_d    = 1'b0;
                    sen_d   = 1'b0;
                    state_d = CHECK;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                    sd_d  = word_q[bit_idx];
                end
            end
            CHECK: begin
                done_d  = 1'b1;
                err_d   = mismatch;
                state_d = IDLE;
                if (mismatch && (err_cnt_q != '1)) begin
                    err_cnt_d = err_cnt_q + ERR_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                sd_d    = 1'b0;
                sen_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            word_q    <= '0;
            sd_q      <= 1'b0;
            sen_q     <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            word_q    <= word_d;
            sd_q      <= sd_d;
            sen_q     <= sen_d;
            done_q    <= done_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

endmodule
